pic_host_bus_master: RTL and testbench

//  CPU-side initiator for the 8259-style PIC control unit; the other end of its WR/RD/A0/DATA/INTA_ bus.

---
 rtl/pic_host_bus_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_pic_host_bus_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_host_bus_master.sv
// CPU-side bus initiator for an 8259-style PIC: runs the ICW init sequence,
// issues OCW writes / status reads, and services INT with a two-pulse INTA_ cycle.
module pic_host_bus_master #(
    parameter int WR_PULSE   = 2,
    parameter int RD_PULSE   = 2,
    parameter int INTA_PULSE = 2,
    parameter int INTA_GAP   = 2
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       INT,
    output logic [7:0] vec,
    output logic       vec_valid,
    output logic       busy,
    output logic       WR_ENABLE,
    output logic       RD_ENABLE,
    output logic       A0,
    inout  wire  [7:0] DATA,
    output logic       INTA_
);

    localparam int MAX_A = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
    localparam int MAX_B = (INTA_PULSE > INTA_GAP) ? INTA_PULSE : INTA_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_P < 2) ? 1 : $clog2(MAX_P);

    localparam logic [CW-1:0] WR_LAST   = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_PULSE - 1);
    localparam logic [CW-1:0] INTA_LAST = CW'(INTA_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(INTA_GAP - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] W_SETUP  = 4'd1;
    localparam logic [3:0] W_STROBE = 4'd2;
    localparam logic [3:0] W_HOLD   = 4'd3;
    localparam logic [3:0] R_STROBE = 4'd4;
    localparam logic [3:0] R_DONE   = 4'd5;
    localparam logic [3:0] INTA1    = 4'd6;
    localparam logic [3:0] GAP      = 4'd7;
    localparam logic [3:0] INTA2    = 4'd8;
    localparam logic [3:0] V_DONE   = 4'd9;

    logic [3:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    icw1_q, icw2_q, icw3_q, icw4_q;
    logic [1:0]    step, step_nxt;
    logic          step_more;
    logic [7:0]    word_nxt;
    logic          in_init;
    logic [7:0]    wr_data;
    logic          data_oe;
    logic          int_s1, int_s2, armed;
    logic          int_req;
    logic          start_init, accept_cmd;

    assign int_req   = init_done && armed && int_s2;
    assign cmd_ready = (state == IDLE) && init_done && !int_req && !init_start;
    assign busy      = (state != IDLE);
    assign DATA      = data_oe ? wr_data : 8'hzz;

    // ICW3 is skipped in single mode (icw1[1]) and ICW4 when icw1[0] says it is absent.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        step_more = 1'b0;
        step_nxt  = step;
        case (step)
            2'd0: begin
                step_more = 1'b1;
                step_nxt  = 2'd1;
            end
            2'd1: begin
                if (!icw1_q[1]) begin
                    step_more = 1'b1;
                    step_nxt  = 2'd2;
                end else if (icw1_q[0]) begin
                    step_more = 1'b1;
                    step_nxt  = 2'd3;
                end
            end
            2'd2: begin
                if (icw1_q[0]) begin
                    step_more = 1'b1;
                    step_nxt  = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        word_nxt = icw1_q | 8'h10;
        case (step_nxt)
            2'd1:    word_nxt = icw2_q;
            2'd2:    word_nxt = icw3_q;
            2'd3:    word_nxt = icw4_q;
            default: ;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        start_init = 1'b0;
        accept_cmd = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (init_start) begin
                    start_init = 1'b1;
                    state_n    = W_SETUP;
                end else if (int_req) begin
                    state_n = INTA1;
                end else if (cmd_valid && cmd_ready) begin
                    accept_cmd = 1'b1;
                    state_n    = cmd_rd ? R_STROBE : W_SETUP;
                end
            end
            W_SETUP: begin
                cnt_n   = '0;
                state_n = W_STROBE;
            end
            W_STROBE: begin
                if (cnt == WR_LAST) begin
                    cnt_n   = '0;
                    state_n = W_HOLD;
                end
            end
            W_HOLD: begin
                cnt_n   = '0;
                state_n = (in_init && step_more) ? W_SETUP : IDLE;
            end
            R_STROBE: begin
                if (cnt == RD_LAST) begin
                    cnt_n   = '0;
                    state_n = R_DONE;
                end
            end
            INTA1: begin
                if (cnt == INTA_LAST) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = INTA2;
                end
            end
            INTA2: begin
                if (cnt == INTA_LAST) begin
                    cnt_n   = '0;
                    state_n = V_DONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so each pin comes straight off a flop.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state     <= IDLE;
            cnt       <= '0;
            WR_ENABLE <= 1'b0;
            RD_ENABLE <= 1'b0;
            INTA_     <= 1'b1;
            A0        <= 1'b0;
            data_oe   <= 1'b0;
            wr_data   <= 8'h00;
            rd_valid  <= 1'b0;
            vec_valid <= 1'b0;
            rd_data   <= 8'h00;
            vec       <= 8'h00;
            init_done <= 1'b0;
            in_init   <= 1'b0;
            step      <= 2'd0;
            icw1_q    <= 8'h00;
            icw2_q    <= 8'h00;
            icw3_q    <= 8'h00;
            icw4_q    <= 8'h00;
            int_s1    <= 1'b0;
            int_s2    <= 1'b0;
            armed     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= state_n;
            cnt       <= cnt_n;
            WR_ENABLE <= (state_n == W_STROBE);
            RD_ENABLE <= (state_n == R_STROBE) || ((state_n == INTA2) && (cnt_n != '0));
            INTA_     <= !((state_n == INTA1) || (state_n == INTA2));
            data_oe   <= (state_n == W_SETUP) || (state_n == W_STROBE) || (state_n == W_HOLD);
            rd_valid  <= (state_n == R_DONE);
            vec_valid <= (state_n == V_DONE);
            int_s1    <= INT;
            int_s2    <= int_s1;

            if (start_init) begin
                icw1_q  <= icw1;
                icw2_q  <= icw2;
                icw3_q  <= icw3;
                icw4_q  <= icw4;
                step    <= 2'd0;
                in_init <= 1'b1;
                A0      <= 1'b0;
                wr_data <= icw1 | 8'h10;
            end else if (accept_cmd) begin
                A0      <= cmd_a0;
                wr_data <= cmd_data;
            end else if ((state == W_HOLD) && in_init) begin
                if (step_more) begin
                    step    <= step_nxt;
                    A0      <= 1'b1;
                    wr_data <= word_nxt;
                end else begin
                    in_init   <= 1'b0;
                    init_done <= 1'b1;
                end
            end

            if ((state == R_STROBE) && (cnt == RD_LAST)) begin
                rd_data <= DATA;
            end
            if ((state == INTA2) && (cnt == INTA_LAST)) begin
                vec <= DATA;
            end

            if (state == V_DONE) begin
                armed <= 1'b0;
            end else if (!int_s2) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: a small PIC model answers reads and INTA,
// and a negedge monitor checks bus writes, read results and vectors against queues.
module tb_pic_host_bus_master;

    localparam int WR_PULSE   = 2;
    localparam int RD_PULSE   = 2;
    localparam int INTA_PULSE = 2;
    localparam int INTA_GAP   = 2;

    logic       CLK = 1'b0;
    logic       RST_ = 1'b0;
    logic       init_start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
    logic       init_done;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rd = 1'b0;
    logic       cmd_a0 = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       INT = 1'b0;
    logic [7:0] vec;
    logic       vec_valid;
    logic       busy;
    logic       WR_ENABLE;
    logic       RD_ENABLE;
    logic       A0;
    wire  [7:0] DATA;
    logic       INTA_;

    logic [7:0] pic_val = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_vec[$];

    // The PIC drives the bus whenever the master reads (status read or vector cycle).
    assign DATA = RD_ENABLE ? pic_val : 8'hzz;

    always #5 CLK = ~CLK;

    pic_host_bus_master #(
        .WR_PULSE  (WR_PULSE),
        .RD_PULSE  (RD_PULSE),
        .INTA_PULSE(INTA_PULSE),
        .INTA_GAP  (INTA_GAP)
    ) dut (
        .CLK       (CLK),
        .RST_      (RST_),
        .init_start(init_start),
        .icw1      (icw1),
        .icw2      (icw2),
        .icw3      (icw3),
        .icw4      (icw4),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rd    (cmd_rd),
        .cmd_a0    (cmd_a0),
        .cmd_data  (cmd_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .INT       (INT),
        .vec       (vec),
        .vec_valid (vec_valid),
        .busy      (busy),
        .WR_ENABLE (WR_ENABLE),
        .RD_ENABLE (RD_ENABLE),
        .A0        (A0),
        .DATA      (DATA),
        .INTA_     (INTA_)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: write strobe shape and data, read results, vectors.
    logic       prev_we   = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         we_len    = 0;

    always @(negedge CLK) begin
        if (!RST_) begin
            prev_we <= 1'b0;
            we_len  <= 0;
        end else begin
            check("strobe_exclusive",
                  32'(!(WR_ENABLE && RD_ENABLE) && !(WR_ENABLE && !INTA_)), 32'(1));
            if (WR_ENABLE && !prev_we) begin
                check("wr_setup_stable", 32'(DATA), 32'(prev_data));
                check("wr_expected", 32'(exp_wr.size() > 0), 32'(1));
                if (exp_wr.size() > 0) begin
                    check("wr_a0_data", 32'({A0, DATA}), 32'(exp_wr.pop_front()));
                end
            end
            if (!WR_ENABLE && prev_we) begin
                check("wr_width", 32'(we_len), 32'(WR_PULSE));
                check("wr_hold_stable", 32'(DATA), 32'(prev_data));
            end
            if (rd_valid) begin
                check("rd_expected", 32'(exp_rd.size() > 0), 32'(1));
                if (exp_rd.size() > 0) begin
                    check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                end
            end
            if (vec_valid) begin
                check("vec_expected", 32'(exp_vec.size() > 0), 32'(1));
                if (exp_vec.size() > 0) begin
                    check("vec", 32'(vec), 32'(exp_vec.pop_front()));
                end
            end
            we_len    <= WR_ENABLE ? we_len + 1 : 0;
            prev_we   <= WR_ENABLE;
            prev_data <= DATA;
        end
    end

    task automatic pulse_init(input logic [7:0] w1, input logic [7:0] w2,
                              input logic [7:0] w3, input logic [7:0] w4);
        icw1 = w1;
        icw2 = w2;
        icw3 = w3;
        icw4 = w4;
        init_start = 1'b1;
        @(negedge CLK);
        init_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy !== 1'b0 && i < 200) begin
            @(negedge CLK);
            i++;
        end
        check(tag, 32'(busy), 32'(0));
    endtask

    task automatic send_cmd(input logic rd, input logic a0, input logic [7:0] d, input string tag);
        int i = 0;
        cmd_rd    = rd;
        cmd_a0    = a0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && i < 200) begin
            @(negedge CLK);
            i++;
        end
        check(tag, 32'(cmd_ready), 32'(1));
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int i;
        int lows;

        // Reset values
        repeat (3) @(negedge CLK);
        check("reset_pins", 32'({WR_ENABLE, RD_ENABLE, INTA_, A0, init_done, cmd_ready,
                                 busy, rd_valid, vec_valid}), 32'(9'b001000000));
        check("reset_rd_data", 32'(rd_data), 32'(0));
        check("reset_vec", 32'(vec), 32'(0));
        RST_ = 1'b1;
        @(negedge CLK);

        // INT before init is ignored
        INT  = 1'b1;
        lows = 0;
        repeat (10) begin
            @(negedge CLK);
            if (INTA_ !== 1'b1) lows++;
        end
        check("int_ignored_pre_init", 32'(lows), 32'(0));
        INT = 1'b0;
        repeat (4) @(negedge CLK);

        // Init: ICW1, ICW2, ICW4 (no ICW3)
        exp_wr.push_back({1'b0, 8'h13});
        exp_wr.push_back({1'b1, 8'h20});
        exp_wr.push_back({1'b1, 8'h03});
        pulse_init(8'h13, 8'h20, 8'h55, 8'h03);
        wait_idle("init1_idle");
        check("init1_done", 32'(init_done), 32'(1));
        check("init1_all_writes", 32'(exp_wr.size()), 32'(0));

        // Init with ICW3 and ICW4
        exp_wr.push_back({1'b0, 8'h11});
        exp_wr.push_back({1'b1, 8'h20});
        exp_wr.push_back({1'b1, 8'h04});
        exp_wr.push_back({1'b1, 8'h01});
        pulse_init(8'h11, 8'h20, 8'h04, 8'h01);
        wait_idle("init2_idle");
        check("init2_all_writes", 32'(exp_wr.size()), 32'(0));

        // Init with two writes only, bit4 forced
        exp_wr.push_back({1'b0, 8'h12});
        exp_wr.push_back({1'b1, 8'h20});
        pulse_init(8'h02, 8'h20, 8'h04, 8'h01);
        wait_idle("init3_idle");
        check("init3_all_writes", 32'(exp_wr.size()), 32'(0));
        check("init3_done", 32'(init_done), 32'(1));

        // OCW write
        exp_wr.push_back({1'b1, 8'hF0});
        send_cmd(1'b0, 1'b1, 8'hF0, "wr_cmd_accept");
        wait_idle("wr_cmd_idle");
        check("wr_cmd_written", 32'(exp_wr.size()), 32'(0));

        // Status read
        pic_val = 8'h5A;
        exp_rd.push_back(8'h5A);
        send_cmd(1'b1, 1'b0, 8'h00, "rd_cmd_accept");
        wait_idle("rd_cmd_idle");
        check("rd_cmd_done", 32'(exp_rd.size()), 32'(0));
        check("rd_data_value", 32'(rd_data), 32'(8'h5A));

        // Interrupt acknowledge, cycle by cycle
        pic_val = 8'h23;
        exp_vec.push_back(8'h23);
        INT = 1'b1;
        i   = 0;
        while (INTA_ !== 1'b0 && i < 50) begin
            @(negedge CLK);
            i++;
        end
        check("inta_start", 32'(INTA_), 32'(0));
        for (int k = 0; k < INTA_PULSE; k++) begin
            check("inta1_pins", 32'({INTA_, RD_ENABLE}), 32'(2'b00));
            @(negedge CLK);
        end
        for (int k = 0; k < INTA_GAP; k++) begin
            check("gap_pins", 32'({INTA_, RD_ENABLE}), 32'(2'b10));
            @(negedge CLK);
        end
        for (int k = 0; k < INTA_PULSE; k++) begin
            check("inta2_pins", 32'({INTA_, RD_ENABLE}), 32'({1'b0, k >= 1}));
            @(negedge CLK);
        end
        check("v_done_pins", 32'({INTA_, RD_ENABLE, vec_valid}), 32'(3'b101));

        // INT held high must not retrigger
        lows = 0;
        repeat (20) begin
            @(negedge CLK);
            if (INTA_ !== 1'b1) lows++;
        end
        check("no_retrigger", 32'(lows), 32'(0));
        check("vec_done", 32'(exp_vec.size()), 32'(0));
        check("vec_value", 32'(vec), 32'(8'h23));
        check("rd_data_held", 32'(rd_data), 32'(8'h5A));
        INT = 1'b0;
        repeat (4) @(negedge CLK);

        // INT and a command together: acknowledge first, then the command
        pic_val = 8'h3C;
        exp_vec.push_back(8'h3C);
        exp_wr.push_back({1'b0, 8'h0B});
        INT = 1'b1;
        repeat (2) @(negedge CLK);
        check("cmd_blocked_by_int", 32'(cmd_ready), 32'(0));
        cmd_rd    = 1'b0;
        cmd_a0    = 1'b0;
        cmd_data  = 8'h0B;
        cmd_valid = 1'b1;
        i = 0;
        while (INTA_ !== 1'b0 && WR_ENABLE !== 1'b1 && i < 50) begin
            @(negedge CLK);
            i++;
        end
        check("inta_before_cmd", 32'({INTA_, WR_ENABLE}), 32'(2'b00));
        send_cmd(1'b0, 1'b0, 8'h0B, "held_cmd_accept");
        wait_idle("held_cmd_idle");
        check("held_cmd_written", 32'(exp_wr.size()), 32'(0));
        check("held_vec_done", 32'(exp_vec.size()), 32'(0));
        INT = 1'b0;
        repeat (4) @(negedge CLK);

        // Reset in the middle of INTA2 drops the strobes at once
        INT = 1'b1;
        i   = 0;
        while (!(INTA_ === 1'b0 && RD_ENABLE === 1'b1) && i < 50) begin
            @(negedge CLK);
            i++;
        end
        check("reach_inta2", 32'({INTA_, RD_ENABLE}), 32'(2'b01));
        #2 RST_ = 1'b0;
        #1;
        check("abort_pins", 32'({INTA_, RD_ENABLE, WR_ENABLE, busy, init_done, vec_valid}),
              32'(6'b100000));
        check("abort_vec", 32'(vec), 32'(0));
        repeat (3) @(negedge CLK);
        RST_ = 1'b1;
        lows = 0;
        repeat (10) begin
            @(negedge CLK);
            if (INTA_ !== 1'b1 || vec_valid !== 1'b0) lows++;
        end
        check("int_ignored_after_reset", 32'(lows), 32'(0));
        INT = 1'b0;
        repeat (2) @(negedge CLK);

        check("final_wr_queue", 32'(exp_wr.size()), 32'(0));
        check("final_rd_queue", 32'(exp_rd.size()), 32'(0));
        check("final_vec_queue", 32'(exp_vec.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
